// File: rtl/seq_pkg.sv
// Shared encodings for the note-sequence stepper: play modes and FSM states.
package seq_pkg;

  localparam logic [1:0] MODE_LOOP     = 2'd0;
  localparam logic [1:0] MODE_ONESHOT  = 2'd1;
  localparam logic [1:0] MODE_PINGPONG = 2'd2;
  localparam logic [1:0] MODE_REVLOOP  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PLAY_FWD = 2'd1,
    ST_PLAY_REV = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

endpackage

// File: rtl/sequence_stepper.sv
// Note-index generator for the tone synthesiser: steps a ROM address on each tempo
// strobe in loop, one-shot, ping-pong or reverse-loop order, with status pulses.
module sequence_stepper
  import seq_pkg::*;
#(
  parameter int unsigned BW      = 8,
  parameter int unsigned MAX_LEN = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          strb_i,
  input  logic          start_i,
  input  logic          stop_i,
  input  logic [1:0]    mode_i,
  input  logic [BW-1:0] lastIdx_i,
  output logic [BW-1:0] noteIndex_o,
  output logic          playing_o,
  output logic          done_o,
  output logic          wrap_o,
  output logic [1:0]    dbg_state
);

  localparam logic [BW-1:0] LAST_MAX = BW'(MAX_LEN - 1);

  state_t        state, nxt_state;
  logic [BW-1:0] idx, nxt_idx;
  logic [BW-1:0] last, nxt_last;
  logic [1:0]    mode, nxt_mode;
  logic          nxt_done, nxt_wrap, nxt_playing;
  logic [BW-1:0] start_last;

  // Sequence length is clamped once, at start, so every later compare uses the latched bound.
  assign start_last = (lastIdx_i > LAST_MAX) ? LAST_MAX : lastIdx_i;

  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    nxt_last  = last;
    nxt_mode  = mode;
    nxt_done  = 1'b0;
    nxt_wrap  = 1'b0;
    if (stop_i) begin
      nxt_state = ST_IDLE;
      nxt_idx   = '0;
    end else if (start_i) begin
      nxt_mode = mode_i;
      nxt_last = start_last;
      if (mode_i == MODE_REVLOOP) begin
        nxt_state = ST_PLAY_REV;
        nxt_idx   = start_last;
      end else begin
        nxt_state = ST_PLAY_FWD;
        nxt_idx   = '0;
      end
    end else begin
      case (state)
        ST_IDLE: nxt_idx = '0;
        ST_PLAY_FWD: begin
          if (strb_i) begin
            if (idx < last) begin
              nxt_idx = idx + 1'b1;
            end else if (mode == MODE_ONESHOT) begin
              nxt_state = ST_DONE;
              nxt_done  = 1'b1;
            end else if (mode == MODE_PINGPONG) begin
              nxt_wrap = 1'b1;
              if (last != '0) begin
                nxt_idx   = last - 1'b1;
                nxt_state = ST_PLAY_REV;
              end
            end else begin
              nxt_idx  = '0;
              nxt_wrap = 1'b1;
            end
          end
        end
        ST_PLAY_REV: begin
          if (strb_i) begin
            if (idx != '0) begin
              nxt_idx = idx - 1'b1;
            end else if (mode == MODE_PINGPONG) begin
              nxt_wrap = 1'b1;
              if (last != '0) begin
                nxt_idx   = {{(BW-1){1'b0}}, 1'b1};
                nxt_state = ST_PLAY_FWD;
              end
            end else begin
              nxt_idx  = last;
              nxt_wrap = 1'b1;
            end
          end
        end
        ST_DONE: ;
        default: begin
          nxt_state = ST_IDLE;
          nxt_idx   = '0;
        end
      endcase
    end
    nxt_playing = (nxt_state == ST_PLAY_FWD) || (nxt_state == ST_PLAY_REV);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      idx       <= '0;
      last      <= '0;
      mode      <= MODE_LOOP;
      playing_o <= 1'b0;
      done_o    <= 1'b0;
      wrap_o    <= 1'b0;
    end else begin
      state     <= nxt_state;
      idx       <= nxt_idx;
      last      <= nxt_last;
      mode      <= nxt_mode;
      playing_o <= nxt_playing;
      done_o    <= nxt_done;
      wrap_o    <= nxt_wrap;
    end
  end

  assign noteIndex_o = idx;
  assign dbg_state   = state;

endmodule

// File: tb/tb_sequence_stepper.sv
// Directed bench for sequence_stepper: the driver queues hand-computed responses,
// a monitor pops and compares one entry per clock after each edge.
module tb_sequence_stepper;
  import seq_pkg::*;

  localparam int BW = 8;
  localparam int W  = BW + 5;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          strb_i = 1'b0;
  logic          start_i = 1'b0;
  logic          stop_i = 1'b0;
  logic [1:0]    mode_i = 2'd0;
  logic [BW-1:0] lastIdx_i = '0;
  logic [BW-1:0] noteIndex_o;
  logic          playing_o, done_o, wrap_o;
  logic [1:0]    dbg_state;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int step_no = 0;

  sequence_stepper #(.BW(BW), .MAX_LEN(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .strb_i(strb_i), .start_i(start_i),
    .stop_i(stop_i), .mode_i(mode_i), .lastIdx_i(lastIdx_i),
    .noteIndex_o(noteIndex_o), .playing_o(playing_o), .done_o(done_o),
    .wrap_o(wrap_o), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  // Drive one cycle of inputs at the falling edge and queue the response due after the next rise.
  task automatic drive(input logic rst, input logic start, input logic stop, input logic strb,
                       input logic [1:0] md, input logic [BW-1:0] li,
                       input logic [BW-1:0] e_idx, input state_t e_st,
                       input logic e_play, input logic e_done, input logic e_wrap);
    @(negedge clk_i);
    rst_i     = rst;
    start_i   = start;
    stop_i    = stop;
    strb_i    = strb;
    mode_i    = md;
    lastIdx_i = li;
    exp_q.push_back({e_idx, 2'(e_st), e_play, e_done, e_wrap});
  endtask

  // Strobe with scrambled mode/last inputs: they must be ignored outside start.
  task automatic strobe(input logic [BW-1:0] e_idx, input state_t e_st,
                        input logic e_play, input logic e_done, input logic e_wrap);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 2'($urandom_range(0, 3)), BW'($urandom_range(0, 255)),
          e_idx, e_st, e_play, e_done, e_wrap);
  endtask

  task automatic start(input logic [1:0] md, input logic [BW-1:0] li,
                       input logic [BW-1:0] e_idx, input state_t e_st);
    drive(1'b0, 1'b1, 1'b0, 1'b0, md, li, e_idx, e_st, 1'b1, 1'b0, 1'b0);
  endtask

  // scoreboard monitor
  always @(posedge clk_i) begin
    logic [W-1:0] got, exp;
    #1;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = {noteIndex_o, dbg_state, playing_o, done_o, wrap_o};
      checks++;
      step_no++;
      if (got !== exp) begin
        errors++;
        $display("FAIL step %0d: got idx=%0d st=%0d play=%b done=%b wrap=%b, expected idx=%0d st=%0d play=%b done=%b wrap=%b",
                 step_no, got[W-1:5], got[4:3], got[2], got[1], got[0],
                 exp[W-1:5], exp[4:3], exp[2], exp[1], exp[0]);
      end
    end
  end

  initial begin
    // reset, idle strobe ignored
    drive(1, 0, 0, 0, 0, 0, 0, ST_IDLE, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 0, 0, ST_IDLE, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 5, 0, ST_IDLE, 0, 0, 0);

    // loop, last=3
    start(MODE_LOOP, 3, 0, ST_PLAY_FWD);
    strobe(1, ST_PLAY_FWD, 1, 0, 0);
    strobe(2, ST_PLAY_FWD, 1, 0, 0);
    strobe(3, ST_PLAY_FWD, 1, 0, 0);
    strobe(0, ST_PLAY_FWD, 1, 0, 1);
    strobe(1, ST_PLAY_FWD, 1, 0, 0);
    drive(0, 0, 0, 0, 2, 9, 1, ST_PLAY_FWD, 1, 0, 0);
    strobe(2, ST_PLAY_FWD, 1, 0, 0);
    strobe(3, ST_PLAY_FWD, 1, 0, 0);
    strobe(0, ST_PLAY_FWD, 1, 0, 1);
    strobe(1, ST_PLAY_FWD, 1, 0, 0);

    // one-shot, last=2 (restart while playing)
    start(MODE_ONESHOT, 2, 0, ST_PLAY_FWD);
    strobe(1, ST_PLAY_FWD, 1, 0, 0);
    strobe(2, ST_PLAY_FWD, 1, 0, 0);
    strobe(2, ST_DONE, 0, 1, 0);
    strobe(2, ST_DONE, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 2, ST_DONE, 0, 0, 0);

    // ping-pong, last=3 (restart from DONE)
    start(MODE_PINGPONG, 3, 0, ST_PLAY_FWD);
    strobe(1, ST_PLAY_FWD, 1, 0, 0);
    strobe(2, ST_PLAY_FWD, 1, 0, 0);
    strobe(3, ST_PLAY_FWD, 1, 0, 0);
    strobe(2, ST_PLAY_REV, 1, 0, 1);
    strobe(1, ST_PLAY_REV, 1, 0, 0);
    strobe(0, ST_PLAY_REV, 1, 0, 0);
    strobe(1, ST_PLAY_FWD, 1, 0, 1);
    strobe(2, ST_PLAY_FWD, 1, 0, 0);

    // reverse loop, last=2
    start(MODE_REVLOOP, 2, 2, ST_PLAY_REV);
    strobe(1, ST_PLAY_REV, 1, 0, 0);
    strobe(0, ST_PLAY_REV, 1, 0, 0);
    strobe(2, ST_PLAY_REV, 1, 0, 1);
    strobe(1, ST_PLAY_REV, 1, 0, 0);

    // last==0 corner cases
    start(MODE_PINGPONG, 0, 0, ST_PLAY_FWD);
    strobe(0, ST_PLAY_FWD, 1, 0, 1);
    strobe(0, ST_PLAY_FWD, 1, 0, 1);
    start(MODE_REVLOOP, 0, 0, ST_PLAY_REV);
    strobe(0, ST_PLAY_REV, 1, 0, 1);

    // clamp: last=20 with MAX_LEN=8 behaves as last=7
    start(MODE_LOOP, 20, 0, ST_PLAY_FWD);
    for (int i = 1; i <= 7; i++) strobe(BW'(i), ST_PLAY_FWD, 1, 0, 0);
    strobe(0, ST_PLAY_FWD, 1, 0, 1);
    start(MODE_REVLOOP, 200, 7, ST_PLAY_REV);

    // start and strobe together: strobe ignored
    drive(0, 1, 0, 1, MODE_LOOP, 5, 0, ST_PLAY_FWD, 1, 0, 0);
    strobe(1, ST_PLAY_FWD, 1, 0, 0);

    // stop beats start and strobe; idle holds 0
    drive(0, 1, 1, 1, MODE_REVLOOP, 4, 0, ST_IDLE, 0, 0, 0);
    strobe(0, ST_IDLE, 0, 0, 0);

    // reset mid-play
    start(MODE_LOOP, 3, 0, ST_PLAY_FWD);
    strobe(1, ST_PLAY_FWD, 1, 0, 0);
    strobe(2, ST_PLAY_FWD, 1, 0, 0);
    strobe(3, ST_PLAY_FWD, 1, 0, 0);
    drive(1, 0, 0, 1, 0, 0, 0, ST_IDLE, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, ST_IDLE, 0, 0, 0);

    // drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk_i);
    @(negedge clk_i);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses still pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
